sap1_fetch_unit: RTL and testbench
==================================

# sap1_fetch_unit

Instruction fetch stage of the SAP-1 datapath, sitting between the controller and the program ROM. It holds the program counter (PC) and memory address register (MAR) and drives the ROM address and output-enable. It captures the returned ROM word into the instruction register (IR) and presents the opcode/operand split to the controller with a one-cycle valid pulse. The fetch runs the classic T1 (address), T2 (increment) and T3 (memory) sequence.

## Interface
- WordSize, 8, ROM word width and IR width
- AddressSize, 4, ROM address width; also PC and MAR width
- OpcodeBits, 4, upper IR bits forming the opcode; operand = remaining WordSize-OpcodeBits low bits
- Clock/reset (already decided): one clock; reset is asynchronous and active-low.
- CLK  in  1  system clock, all state on rising edge
- CLR_bar  in  1  asynchronous active-low reset
- fetch_req  in  1  request one instruction fetch; sampled in IDLE and DONE
- jump_en  in  1  load PC from jump_addr; honoured only in IDLE
- jump_addr  in  AddressSize  jump target
- halt  in  1  stop fetching; sampled in IDLE and DONE
- ROM_address  out  AddressSize  MAR contents
- CE_bar  out  1  ROM output enable: 1 = ROM drives ROM_data, 0 = ROM output floats
- ROM_data  in  WordSize  ROM read data, combinational from ROM_address
- ir_valid  out  1  one-cycle pulse: IR/opcode/operand hold a newly fetched word
- opcode  out  OpcodeBits  IR[WordSize-1 -: OpcodeBits]
- operand  out  WordSize-OpcodeBits  IR low bits
- pc  out  AddressSize  current PC
- busy  out  1  high in ADDR, INC, MEM
- halted  out  1  high in HALTED

## Operation
- States: IDLE, ADDR, INC, MEM, DONE, HALTED. Encoding is free; all outputs are registered or pure state decodes.
- IDLE transitions, in priority order:
  - halt -> HALTED.
  - Else fetch_req -> ADDR.
  - jump_en in IDLE loads PC <= jump_addr on the same edge and may coincide with the fetch_req transition. That fetch then reads jump_addr.
- ADDR (T1): MAR <= PC; -> INC.
- INC (T2): PC <= PC + 1, modulo 2^AddressSize (15 -> 0 wraps for default); -> MEM.
- MEM (T3): CE_bar = 1 for exactly this state. On the exiting edge IR <= ROM_data; -> DONE.
- DONE: ir_valid = 1. Transitions, in priority order:
  - halt -> HALTED.
  - Else fetch_req -> ADDR (back-to-back fetch).
  - Else -> IDLE.
- HALTED: absorbing until CLR_bar. fetch_req and jump_en are ignored; CE_bar = 0.
- halt asserted during ADDR/INC/MEM is not sampled. The in-flight fetch completes, and HALTED is reached only if halt is still high in DONE.
- jump_en outside IDLE is ignored; the PC is unchanged by it.
- CE_bar is 0 in every state except MEM, so the ROM never contends on the bus outside T3.
- IR, and therefore opcode/operand, is held stable between captures.

## Timing
- Reset (CLR_bar low, asynchronous, effective immediately, including mid-fetch):
  - State: IDLE.
  - Registers: PC = 0, MAR = 0 (ROM_address = 0), IR = 0.
  - Outputs: CE_bar = 0, ir_valid = 0, busy = 0, halted = 0.
  - An aborted fetch leaves no IR update and PC = 0.
- Latency: fetch_req high at edge E0 (in IDLE):
  - ADDR during cycle 1, INC during cycle 2, MEM (CE_bar = 1) during cycle 3.
  - IR captured at edge E3; ir_valid high during cycle 4.
- Throughput with fetch_req held high: one instruction per 4 cycles; ir_valid pulses every 4th cycle.
- ROM_address is stable for the whole MEM cycle, because MAR was loaded two edges earlier.
- pc reflects the incremented value from the INC->MEM edge onward.

## Test plan
- Reset: hold CLR_bar low mid-MEM.
  - Required: immediately CE_bar = 0, ROM_address = 0, pc = 0, ir_valid = 0.
  - After release, the first fetch reads address 0.
- Single fetch, ROM[0] = 0x1E: pulse fetch_req.
  - Required: CE_bar high only in cycle 3; ir_valid in cycle 4 with opcode = 0x1, operand = 0xE; pc = 1.
- Back-to-back, ROM[0..2] = 0x1E, 0x2F, 0xE0; fetch_req held high.
  - Required: ir_valid at cycles 4, 8, 12 with IR = 0x1E, 0x2F, 0xE0; pc = 3.
- Wrap: jump_en with jump_addr = 15 plus fetch_req in IDLE, ROM[15] = 0xF0.
  - Required: IR = 0xF0, pc = 0; the next fetch reads address 0.
- Jump ignored: jump_en pulsed during INC.
  - Required: PC unaffected; sequential address used on the next fetch.
- Halt:
  - halt raised during ADDR: the fetch completes with ir_valid, then halted = 1.
  - Subsequent fetch_req/jump_en produce no CE_bar activity and no pc change until CLR_bar.

Source files
------------

// File: rtl/sap1_fetch_unit.sv
// sap1_fetch_unit: SAP-1 instruction fetch stage.
//
// Holds the program counter (PC) and memory address register (MAR), drives the
// program ROM address and output-enable, and captures the returned word into the
// instruction register (IR). A fetch runs T1 (ADDR: MAR <= PC), T2 (INC: PC++),
// T3 (MEM: ROM enabled, IR <= ROM_data), and then presents the result for one
// cycle in DONE.
//
// Ports:
//   CLK          system clock, all state on the rising edge
//   CLR_bar      asynchronous active-low reset
//   fetch_req    request one fetch; sampled in IDLE and DONE
//   jump_en      load PC from jump_addr; honoured only in IDLE
//   jump_addr    jump target
//   halt         stop fetching; sampled in IDLE and DONE
//   ROM_address  MAR contents
//   CE_bar       ROM output enable (1 = ROM drives ROM_data); high only in MEM
//   ROM_data     ROM read data, combinational from ROM_address
//   ir_valid     one-cycle pulse: IR/opcode/operand hold a newly fetched word
//   opcode       IR upper OpcodeBits bits
//   operand      IR remaining low bits
//   pc           current PC
//   busy         high in ADDR, INC, MEM
//   halted       high in HALTED
module sap1_fetch_unit #(
  parameter int unsigned WordSize    = 8,
  parameter int unsigned AddressSize = 4,
  parameter int unsigned OpcodeBits  = 4
) (
  input  logic                           CLK,
  input  logic                           CLR_bar,
  input  logic                           fetch_req,
  input  logic                           jump_en,
  input  logic [AddressSize-1:0]         jump_addr,
  input  logic                           halt,
  output logic [AddressSize-1:0]         ROM_address,
  output logic                           CE_bar,
  input  logic [WordSize-1:0]            ROM_data,
  output logic                           ir_valid,
  output logic [OpcodeBits-1:0]          opcode,
  output logic [WordSize-OpcodeBits-1:0] operand,
  output logic [AddressSize-1:0]         pc,
  output logic                           busy,
  output logic                           halted
);

  localparam int unsigned OperandBits = WordSize - OpcodeBits;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StInc,
    StMem,
    StDone,
    StHalted
  } state_e;

  state_e                 state_q, state_d;
  logic [AddressSize-1:0] pc_q, pc_d;
  logic [AddressSize-1:0] mar_q, mar_d;
  logic [WordSize-1:0]    ir_q, ir_d;

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state_q <= StIdle;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;

    case (state_q)
      StIdle: begin
        // A jump may coincide with fetch_req; the following ADDR then reads
        // the jump target because PC is loaded on this same edge.
        if (jump_en) begin
          pc_d = jump_addr;
        end
        if (halt) begin
          state_d = StHalted;
        end else if (fetch_req) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        mar_d   = pc_q;
        state_d = StInc;
      end
      StInc: begin
        // Natural modulo-2^AddressSize wrap.
        pc_d    = pc_q + AddressSize'(1);
        state_d = StMem;
      end
      StMem: begin
        ir_d    = ROM_data;
        state_d = StDone;
      end
      StDone: begin
        if (halt) begin
          state_d = StHalted;
        end else if (fetch_req) begin
          state_d = StAddr;
        end else begin
          state_d = StIdle;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All outputs are register contents or pure state decodes.
  assign ROM_address = mar_q;
  assign pc          = pc_q;
  assign opcode      = ir_q[WordSize-1 -: OpcodeBits];
  assign operand     = ir_q[OperandBits-1:0];
  assign CE_bar      = (state_q == StMem);
  assign ir_valid    = (state_q == StDone);
  assign busy        = (state_q == StAddr) || (state_q == StInc) || (state_q == StMem);
  assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Directed bench for sap1_fetch_unit. Inputs change and outputs are sampled
// 1 time unit after each rising edge, so "cycle k" is observed right after
// edge E(k-1).
module tb_sap1_fetch_unit;

  logic       CLK = 1'b0;
  logic       CLR_bar;
  logic       fetch_req;
  logic       jump_en;
  logic [3:0] jump_addr;
  logic       halt;
  logic [3:0] ROM_address;
  logic       CE_bar;
  logic [7:0] ROM_data;
  logic       ir_valid;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [3:0] pc;
  logic       busy;
  logic       halted;

  logic [7:0] rom [16];
  logic [7:0] exp_ir [3];

  int vectors = 0;
  int errors  = 0;

  always #5 CLK = ~CLK;

  // ROM floats (modelled as zero) unless enabled.
  assign ROM_data = CE_bar ? rom[ROM_address] : 8'h00;

  sap1_fetch_unit #(
    .WordSize   (8),
    .AddressSize(4),
    .OpcodeBits (4)
  ) dut (
    .CLK        (CLK),
    .CLR_bar    (CLR_bar),
    .fetch_req  (fetch_req),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .halt       (halt),
    .ROM_address(ROM_address),
    .CE_bar     (CE_bar),
    .ROM_data   (ROM_data),
    .ir_valid   (ir_valid),
    .opcode     (opcode),
    .operand    (operand),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR_bar = 1'b0;
    #3;
    CLR_bar = 1'b1;
  endtask

  task automatic test_reset();
    CLR_bar = 1'b0;
    step();
    step();
    vectors++;
    if ({CE_bar, ir_valid, busy, halted} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got ce/v/busy/halt=%b exp 0000",
               {CE_bar, ir_valid, busy, halted});
    end
    vectors++;
    if ({ROM_address, pc, opcode, operand} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: got addr=%h pc=%h ir=%h%h exp all 0",
               ROM_address, pc, opcode, operand);
    end
    CLR_bar = 1'b1;
    // Start a fetch and abort it in the middle of MEM.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    step();
    vectors++;
    if ({CE_bar, pc} !== 5'b1_0001) begin
      errors++;
      $display("FAIL reset_pre_mem: got ce=%b pc=%h exp ce=1 pc=1", CE_bar, pc);
    end
    #2;
    CLR_bar = 1'b0;
    #1;
    vectors++;
    if ({CE_bar, ROM_address, pc, ir_valid, busy} !== 11'b0) begin
      errors++;
      $display("FAIL reset_async: got ce=%b addr=%h pc=%h v=%b busy=%b exp all 0",
               CE_bar, ROM_address, pc, ir_valid, busy);
    end
    step();
    CLR_bar = 1'b1;
    step();
    vectors++;
    if ({opcode, operand, pc, ir_valid, busy} !== 14'b0) begin
      errors++;
      $display("FAIL reset_abort: got ir=%h%h pc=%h v=%b busy=%b exp all 0",
               opcode, operand, pc, ir_valid, busy);
    end
  endtask

  task automatic test_single_fetch();
    fetch_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      fetch_req = 1'b0;
      vectors++;
      if ({CE_bar, busy, ir_valid} !== {c == 3, c <= 3, c == 4}) begin
        errors++;
        $display("FAIL single_cycle%0d: got ce/busy/v=%b exp %b", c,
                 {CE_bar, busy, ir_valid}, {c == 3, c <= 3, c == 4});
      end
      if (c == 3) begin
        vectors++;
        if (ROM_address !== 4'h0) begin
          errors++;
          $display("FAIL single_addr: got %h exp 0", ROM_address);
        end
      end
      if (c == 4) begin
        vectors++;
        if ({opcode, operand, pc} !== 12'h1E1) begin
          errors++;
          $display("FAIL single_result: got op=%h opd=%h pc=%h exp op=1 opd=e pc=1",
                   opcode, operand, pc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_ir[0] = 8'h1E;
    exp_ir[1] = 8'h2F;
    exp_ir[2] = 8'hE0;
    fetch_req = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 12) fetch_req = 1'b0;
      vectors++;
      if ({ir_valid, CE_bar} !== {(c % 4) == 0 && c <= 12, (c % 4) == 3}) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got v/ce=%b exp %b", c, {ir_valid, CE_bar},
                 {(c % 4) == 0 && c <= 12, (c % 4) == 3});
      end
      if ((c % 4) == 0 && c <= 12) begin
        vectors++;
        if ({opcode, operand} !== exp_ir[c/4-1]) begin
          errors++;
          $display("FAIL b2b_ir%0d: got %h%h exp %h", c / 4, opcode, operand,
                   exp_ir[c/4-1]);
        end
      end
    end
    vectors++;
    if ({pc, busy} !== 5'b0011_0) begin
      errors++;
      $display("FAIL b2b_end: got pc=%h busy=%b exp pc=3 busy=0", pc, busy);
    end
  endtask

  task automatic test_wrap();
    fetch_req = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 4'hF;
    step();
    fetch_req = 1'b0;
    jump_en   = 1'b0;
    vectors++;
    if (pc !== 4'hF) begin
      errors++;
      $display("FAIL wrap_jump_pc: got %h exp f", pc);
    end
    step();
    step();
    vectors++;
    if ({ROM_address, pc, CE_bar} !== 9'b1111_0000_1) begin
      errors++;
      $display("FAIL wrap_mem: got addr=%h pc=%h ce=%b exp addr=f pc=0 ce=1",
               ROM_address, pc, CE_bar);
    end
    step();
    vectors++;
    if ({ir_valid, opcode, operand, pc} !== 13'b1_1111_0000_0000) begin
      errors++;
      $display("FAIL wrap_result: got v=%b ir=%h%h pc=%h exp v=1 ir=f0 pc=0",
               ir_valid, opcode, operand, pc);
    end
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    step();
    step();
    vectors++;
    if ({ir_valid, opcode, operand, pc, ROM_address} !== 17'b1_0001_1110_0001_0000) begin
      errors++;
      $display("FAIL wrap_next: got v=%b ir=%h%h pc=%h addr=%h exp v=1 ir=1e pc=1 addr=0",
               ir_valid, opcode, operand, pc, ROM_address);
    end
    step();
  endtask

  task automatic test_jump_ignored();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    jump_en   = 1'b1;
    jump_addr = 4'h9;
    step();
    jump_en = 1'b0;
    vectors++;
    if ({pc, ROM_address} !== 8'h21) begin
      errors++;
      $display("FAIL jump_ign_mem: got pc=%h addr=%h exp pc=2 addr=1", pc, ROM_address);
    end
    step();
    vectors++;
    if ({opcode, operand} !== 8'h2F) begin
      errors++;
      $display("FAIL jump_ign_ir: got %h%h exp 2f", opcode, operand);
    end
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    step();
    vectors++;
    if (ROM_address !== 4'h2) begin
      errors++;
      $display("FAIL jump_ign_next_addr: got %h exp 2", ROM_address);
    end
    step();
    vectors++;
    if ({ir_valid, opcode, operand, pc} !== 13'b1_1110_0000_0011) begin
      errors++;
      $display("FAIL jump_ign_next: got v=%b ir=%h%h pc=%h exp v=1 ir=e0 pc=3",
               ir_valid, opcode, operand, pc);
    end
    step();
  endtask

  task automatic test_halt();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    halt      = 1'b1;
    step();
    step();
    vectors++;
    if ({busy, halted, CE_bar} !== 3'b101) begin
      errors++;
      $display("FAIL halt_inflight: got busy/halted/ce=%b exp 101", {busy, halted, CE_bar});
    end
    step();
    vectors++;
    if ({ir_valid, halted, opcode, operand, pc} !== 14'b1_0_0101_1010_0100) begin
      errors++;
      $display("FAIL halt_done: got v=%b h=%b ir=%h%h pc=%h exp v=1 h=0 ir=5a pc=4",
               ir_valid, halted, opcode, operand, pc);
    end
    step();
    halt      = 1'b0;
    fetch_req = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 4'h7;
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if ({halted, busy, ir_valid, CE_bar, pc} !== 8'b1000_0100) begin
        errors++;
        $display("FAIL halt_hold%0d: got h/b/v/ce=%b pc=%h exp 1000 pc=4", c,
                 {halted, busy, ir_valid, CE_bar}, pc);
      end
      step();
    end
    fetch_req = 1'b0;
    jump_en   = 1'b0;
    do_reset();
    vectors++;
    if ({halted, pc} !== 5'b0_0000) begin
      errors++;
      $display("FAIL halt_clear: got h=%b pc=%h exp h=0 pc=0", halted, pc);
    end
    // halt has priority over fetch_req in IDLE.
    halt      = 1'b1;
    fetch_req = 1'b1;
    step();
    halt      = 1'b0;
    fetch_req = 1'b0;
    vectors++;
    if ({halted, busy} !== 2'b10) begin
      errors++;
      $display("FAIL halt_idle: got h/b=%b exp 10", {halted, busy});
    end
    do_reset();
  endtask

  initial begin
    CLR_bar   = 1'b0;
    fetch_req = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 4'h0;
    halt      = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0]  = 8'h1E;
    rom[1]  = 8'h2F;
    rom[2]  = 8'hE0;
    rom[3]  = 8'h5A;
    rom[9]  = 8'h99;
    rom[15] = 8'hF0;

    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_wrap();
    test_jump_ignored();
    test_halt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
